// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central stall / flush / PC-select scheduler for the 5-stage
//             pipeline. Resolves multi-cycle data-memory stalls, EX-stage
//             mispredict recovery, load-use bubbles and ID-stage
//             predicted-taken redirects into one consistent set of pipeline
//             register enables, flushes and the PC mux select.
//  Ports    : clk_i, rst_i              clock, synchronous active-high reset
//             IDRs1_i, IDRs2_i          source registers of the ID instruction
//             EXMemRead_i, EXRd_i       load flag / destination of EX instr
//             IDBranch_i, predict_i     ID branch and predictor taken flag
//             EXBranch_i, mispredict_i  EX branch and mispredict report
//             MEMAccess_i               load/store currently in MEM
//             PCWrite_o, PCSel_o        PC enable, PC mux select
//                                       (00 PC+4, 01 ID target, 10 EX recovery)
//             IFIDWrite_o/IFIDFlush_o, IDEXWrite_o/IDEXFlush_o,
//             EXMEMWrite_o, MEMWBFlush_o pipeline register enables / clears
//             stallCnt_o, mispCnt_o, luCnt_o  event counters (optional)
//  Config   : HAZARD_PERF_EN - when defined, adds saturating 32-bit counters
//             of stall cycles, taken mispredict recoveries and load-use
//             bubbles together with their output ports.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] IDRs1_i,
  input  logic [4:0] IDRs2_i,
  input  logic       EXMemRead_i,
  input  logic [4:0] EXRd_i,
  input  logic       IDBranch_i,
  input  logic       predict_i,
  input  logic       EXBranch_i,
  input  logic       mispredict_i,
  input  logic       MEMAccess_i,
  output logic       PCWrite_o,
  output logic [1:0] PCSel_o,
  output logic       IFIDWrite_o,
  output logic       IFIDFlush_o,
  output logic       IDEXWrite_o,
  output logic       IDEXFlush_o,
  output logic       EXMEMWrite_o,
  output logic       MEMWBFlush_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stallCnt_o,
  output logic [31:0] mispCnt_o,
  output logic [31:0] luCnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // WAIT is entered after the first stall cycle spent in RUN, so it counts
  // down the remaining MEM_LAT-1 cycles; reload value is therefore MEM_LAT-2.
  localparam logic [CNT_W-1:0] C_CNT_LOAD    = (MEM_LAT >= 2) ? CNT_W'(MEM_LAT - 2) : '0;
  localparam bit               C_MEM_STALL   = (MEM_LAT != 0);
  localparam bit               C_SINGLE_STALL = (MEM_LAT == 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_mem_acc;
  logic w_stall;
  logic w_load_use;
  logic w_misp;
  logic w_redirect;
  logic w_misp_take;
  logic w_lu_take;

  // Reset cycle must present default outputs, so memory access is ignored.
  assign w_mem_acc  = MEMAccess_i & ~rst_i;
  assign w_load_use = EXMemRead_i & (EXRd_i != 5'd0) &
                      ((EXRd_i == IDRs1_i) | (EXRd_i == IDRs2_i));
  assign w_misp     = EXBranch_i & mispredict_i;
  assign w_redirect = IDBranch_i & predict_i;

  // --------------------------------------------------------------------------
  // Next-state, stall detection and output arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stall      = 1'b0;
    w_misp_take  = 1'b0;
    w_lu_take    = 1'b0;
    PCWrite_o    = 1'b1;
    PCSel_o      = 2'b00;
    IFIDWrite_o  = 1'b1;
    IFIDFlush_o  = 1'b0;
    IDEXWrite_o  = 1'b1;
    IDEXFlush_o  = 1'b0;
    EXMEMWrite_o = 1'b1;
    MEMWBFlush_o = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_mem_acc && C_MEM_STALL) begin
          w_stall = 1'b1;
          if (C_SINGLE_STALL) begin
            w_state_nxt = ST_RELEASE;
          end else begin
            w_cnt_nxt   = C_CNT_LOAD;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RELEASE: begin
        // The access that caused the stall is still visible on MEMAccess_i
        // while it leaves MEM; it must not re-trigger a stall.
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    // A reset in the middle of WAIT abandons the stall immediately.
    if (rst_i) begin
      w_stall = 1'b0;
    end

    if (rst_i) begin
      // defaults already applied
    end else if (w_stall) begin
      // Whole pipeline frozen; lower-priority hazards are re-presented later.
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXWrite_o  = 1'b0;
      EXMEMWrite_o = 1'b0;
      MEMWBFlush_o = 1'b1;
    end else if (w_misp) begin
      w_misp_take = 1'b1;
      PCSel_o     = 2'b10;
      IFIDFlush_o = 1'b1;
      IDEXFlush_o = 1'b1;
    end else if (w_load_use) begin
      // Holding IF/ID also holds any ID branch redirect until the bubble clears.
      w_lu_take   = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      IDEXFlush_o = 1'b1;
    end else if (w_redirect) begin
      PCSel_o     = 2'b01;
      IFIDFlush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating event counters
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cnt;
  logic [31:0] r_misp_cnt;
  logic [31:0] r_lu_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_misp_cnt  <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_misp_take && (r_misp_cnt != '1)) r_misp_cnt <= r_misp_cnt + 32'd1;
      if (w_lu_take && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + 32'd1;
    end
  end

  assign stallCnt_o = r_stall_cnt;
  assign mispCnt_o  = r_misp_cnt;
  assign luCnt_o    = r_lu_cnt;
`endif

endmodule
`default_nettype wire
